// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting bus timer with one-shot and periodic modes.
// Three word registers (CTRL, PRESET, COUNT); the interrupt is the masked expiry flag.
module timer_dev (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;

    logic ctrl_en;
    logic ctrl_periodic;
    logic ctrl_im;
    logic wr_ctrl;
    logic wr_preset;

    assign ctrl_en       = ctrl_q[0];
    // MODE 10/11 fall back to one-shot.
    assign ctrl_periodic = (ctrl_q[2:1] == 2'b01);
    assign ctrl_im       = ctrl_q[3];

    assign wr_ctrl   = we && (addr == AddrCtrl);
    assign wr_preset = we && (addr == AddrPreset);

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = ctrl_en ? StCnt : StIdle;
            end
            StCnt: begin
                if (!ctrl_en) begin
                    state_d = StIdle;
                end else if (count_q != 32'd0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    state_d   = StInt;
                    pending_d = 1'b1;
                end
            end
            StInt: begin
                if (ctrl_periodic) begin
                    pending_d = 1'b0;
                    state_d   = StLoad;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Software writes override the FSM's EN clear and its pending update.
        if (wr_ctrl) begin
            ctrl_d = din[3:0];
        end
        if (wr_preset) begin
            preset_d = din;
        end
        if (wr_ctrl || wr_preset) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ctrl_q    <= 4'd0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            AddrCtrl:   dout = {28'd0, ctrl_q};
            AddrPreset: dout = preset_q;
            AddrCount:  dout = count_q;
            default:    dout = 32'd0;
        endcase
    end

    assign irq = ctrl_im & pending_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register table, directed timing sequences,
// and randomized traffic checked against a timeline-based reference model.
module tb_timer_dev;

    logic        clk;
    logic        rst_n;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_pass;
    int n_total;

    timer_dev dut (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: a run is a timeline t counted in edges since the reload slot (t=1).
    // With N captured at reload, COUNT = N-(t-2) for t in 2..N+2, and t = N+3 is expiry.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_pend;
    bit          m_run;
    longint      m_t;
    longint      m_cap;

    task automatic model_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_pend   = 1'b0;
        m_run    = 1'b0;
        m_t      = 0;
        m_cap    = 0;
    endtask

    task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
        bit         en;
        bit         per;
        logic [3:0] nctrl;
        en    = m_ctrl[0];
        per   = (m_ctrl[2:1] == 2'b01);
        nctrl = m_ctrl;
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_t   = 1;
            end
        end else if (m_t == 1) begin
            m_cap   = longint'(m_preset);
            m_count = m_preset;
            if (en) m_t = 2;
            else m_run = 1'b0;
        end else if (m_t == m_cap + 3) begin
            if (per) begin
                m_pend = 1'b0;
                m_t    = 1;
            end else begin
                nctrl[0] = 1'b0;
                m_run    = 1'b0;
            end
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if (m_t == m_cap + 3) m_pend = 1'b1;
            else m_count = 32'(m_cap - (m_t - 2));
        end
        if (w && a == 2'd0) begin
            nctrl  = d[3:0];
            m_pend = 1'b0;
        end
        if (w && a == 2'd1) begin
            m_preset = d;
            m_pend   = 1'b0;
        end
        m_ctrl = nctrl;
    endtask

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic model_check();
        logic [31:0] v;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check($sformatf("model dout[addr=%0d]", a), v, m_dout(2'(a)));
        end
        check("model irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_pend});
    endtask

    task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        we = 1'b0;
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] v;
        logic [31:0] exp_cnt;
        int          r;

        vecs[0]  = '{1'b0, 2'd0, 32'd0,         2'd0, 32'd0,         1'b0};
        vecs[1]  = '{1'b0, 2'd0, 32'd0,         2'd1, 32'd0,         1'b0};
        vecs[2]  = '{1'b0, 2'd0, 32'd0,         2'd2, 32'd0,         1'b0};
        vecs[3]  = '{1'b0, 2'd0, 32'd0,         2'd3, 32'd0,         1'b0};
        vecs[4]  = '{1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 32'hDEAD_BEEF, 2'd2, 32'd0,         1'b0};
        vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'd0,         1'b0};
        vecs[7]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd1, 32'h1234_5678, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 32'hFFFF_FFF8, 2'd0, 32'h0000_0008, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 32'h0000_0006, 2'd0, 32'h0000_0006, 1'b0};
        vecs[10] = '{1'b1, 2'd0, 32'd0,         2'd0, 32'd0,         1'b0};
        vecs[11] = '{1'b1, 2'd1, 32'd0,         2'd1, 32'd0,         1'b0};

        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        din     = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;

        // Reset state and idle COUNT
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check($sformatf("reset dout[addr=%0d]", a), v, 32'd0);
        end
        check("reset irq", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 2'd0, 32'd0);
            rd(2'd2, v);
            check("reset count hold", v, 32'd0);
        end

        // Register access table (EN stays 0)
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].we, vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, v);
            check($sformatf("vec%0d dout", i), v, vecs[i].exp_dout);
            check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // One-shot, PRESET=5
        cycle(1'b1, 2'd1, 32'd5);
        cycle(1'b1, 2'd0, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 2'd0, 32'd0);
            exp_cnt = (k < 2) ? 32'd0 : (k <= 7) ? 32'(7 - k) : 32'd0;
            rd(2'd2, v);
            check($sformatf("oneshot count k=%0d", k), v, exp_cnt);
            check($sformatf("oneshot irq k=%0d", k), {31'd0, irq}, (k >= 8) ? 32'd1 : 32'd0);
            rd(2'd0, v);
            check($sformatf("oneshot ctrl k=%0d", k), v, (k >= 9) ? 32'h8 : 32'h9);
        end
        cycle(1'b1, 2'd0, 32'd0);
        check("oneshot irq cleared by ctrl write", {31'd0, irq}, 32'd0);

        // Periodic, PRESET=3: pulse every 6 cycles
        cycle(1'b1, 2'd1, 32'd3);
        cycle(1'b1, 2'd0, 32'hB);
        for (int k = 1; k <= 26; k++) begin
            cycle(1'b0, 2'd0, 32'd0);
            check($sformatf("periodic irq k=%0d", k), {31'd0, irq},
                  (k >= 6 && (k - 6) % 6 == 0) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                r = (k - 2) % 6;
                rd(2'd2, v);
                check($sformatf("periodic count k=%0d", k), v, (r <= 3) ? 32'(3 - r) : 32'd0);
            end
        end
        cycle(1'b1, 2'd0, 32'd0);

        // Masked periodic, then pause and restart
        cycle(1'b1, 2'd1, 32'd4);
        cycle(1'b1, 2'd0, 32'h3);
        for (int k = 1; k <= 17; k++) begin
            cycle(1'b0, 2'd0, 32'd0);
            check($sformatf("masked irq k=%0d", k), {31'd0, irq}, 32'd0);
            if (k >= 2) begin
                r = (k - 2) % 7;
                rd(2'd2, v);
                check($sformatf("masked count k=%0d", k), v, (r <= 4) ? 32'(4 - r) : 32'd0);
            end
        end
        cycle(1'b1, 2'd0, 32'h2);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 2'd0, 32'd0);
            rd(2'd2, v);
            check("paused count frozen", v, 32'd2);
            check("paused irq", {31'd0, irq}, 32'd0);
        end
        cycle(1'b1, 2'd0, 32'h3);
        cycle(1'b0, 2'd0, 32'd0);
        rd(2'd2, v);
        check("restart load slot count", v, 32'd2);
        cycle(1'b0, 2'd0, 32'd0);
        rd(2'd2, v);
        check("restart reload count", v, 32'd4);
        cycle(1'b0, 2'd0, 32'd0);
        rd(2'd2, v);
        check("restart decrement", v, 32'd3);
        cycle(1'b1, 2'd0, 32'd0);
        idle(3);

        // PRESET=0 periodic: IRQ every 3 cycles
        cycle(1'b1, 2'd1, 32'd0);
        cycle(1'b1, 2'd0, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            cycle(1'b0, 2'd0, 32'd0);
            check($sformatf("preset0 irq k=%0d", k), {31'd0, irq}, (k % 3 == 0) ? 32'd1 : 32'd0);
        end
        cycle(1'b1, 2'd0, 32'd0);
        idle(3);

        // PRESET=max, then writes to COUNT and offset 3
        cycle(1'b1, 2'd1, 32'hFFFF_FFFF);
        cycle(1'b1, 2'd0, 32'h1);
        idle(2);
        rd(2'd2, v);
        check("max preset loaded", v, 32'hFFFF_FFFF);
        idle(1);
        rd(2'd2, v);
        check("max preset first decrement", v, 32'hFFFF_FFFE);
        cycle(1'b1, 2'd2, 32'd5);
        rd(2'd2, v);
        check("count write ignored", v, 32'hFFFF_FFFD);
        cycle(1'b1, 2'd3, 32'hFFFF_FFFF);
        rd(2'd2, v);
        check("addr3 write count", v, 32'hFFFF_FFFC);
        rd(2'd0, v);
        check("addr3 write ctrl", v, 32'h1);
        rd(2'd1, v);
        check("addr3 write preset", v, 32'hFFFF_FFFF);
        cycle(1'b1, 2'd0, 32'd0);
        idle(3);

        // Collision: CTRL=0xB written on the one-shot INT edge
        cycle(1'b1, 2'd1, 32'd2);
        cycle(1'b1, 2'd0, 32'h9);
        idle(4);
        check("collision pre-expiry irq", {31'd0, irq}, 32'd0);
        idle(1);
        check("collision expiry irq", {31'd0, irq}, 32'd1);
        cycle(1'b1, 2'd0, 32'hB);
        rd(2'd0, v);
        check("collision ctrl", v, 32'hB);
        check("collision pending cleared", {31'd0, irq}, 32'd0);
        idle(1);
        rd(2'd2, v);
        check("collision load slot", v, 32'd0);
        idle(1);
        rd(2'd2, v);
        check("collision reload", v, 32'd2);
        idle(1);
        rd(2'd2, v);
        check("collision decrement", v, 32'd1);
        cycle(1'b1, 2'd0, 32'd0);
        idle(3);

        // Asynchronous reset while IRQ is high
        cycle(1'b1, 2'd1, 32'd1);
        cycle(1'b1, 2'd0, 32'h9);
        idle(6);
        check("pre-reset irq", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check($sformatf("async reset dout[addr=%0d]", a), v, 32'd0);
        end
        @(posedge clk);
        #5 rst_n = 1'b1;

        // Randomized traffic against the model
        cycle(1'b1, 2'd1, 32'd3);
        cycle(1'b1, 2'd0, 32'hB);
        for (int i = 0; i < 400; i++) begin
            logic        w;
            logic [1:0]  a;
            logic [31:0] d;
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd0 && $urandom_range(0, 3) != 0) d = d | 32'h1;
            if (a == 2'd1) d = 32'($urandom_range(0, 6));
            cycle(w, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
